// File: rtl/ts_packet_fifo_if.sv
// rtl/ts_packet_fifo_if.sv - byte-stream and status bundle for ts_packet_fifo
// Purpose: groups the write byte stream, the read handshake and the status
//          flags of ts_packet_fifo into one connection.
// Signals:
//   wdata, valid_in, sop_in              incoming TS bytes (sop_in marks byte 0)
//   rdata, valid_out, sop_out, ready_out outgoing TS bytes with valid/ready handshake
//   rempty, wfull, pkt_count, drop_pulse FIFO status
// Modports: slave = FIFO side, master = source/sink side.
interface ts_packet_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
);
   logic [DATA_WIDTH-1:0] wdata;
   logic                  valid_in;
   logic                  sop_in;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  valid_out;
   logic                  ready_out;
   logic                  sop_out;
   logic                  rempty;
   logic                  wfull;
   logic [ADDR_WIDTH:0]   pkt_count;
   logic                  drop_pulse;

   modport slave (
      input  wdata, valid_in, sop_in, ready_out,
      output rdata, valid_out, sop_out, rempty, wfull, pkt_count, drop_pulse
   );

   modport master (
      output wdata, valid_in, sop_in, ready_out,
      input  rdata, valid_out, sop_out, rempty, wfull, pkt_count, drop_pulse
   );
endinterface

// File: rtl/ts_packet_fifo.sv
// rtl/ts_packet_fifo.sv - packet-aware store-and-forward FIFO for MPEG2-TS bytes
// Purpose: stores TS bytes speculatively and commits only complete PKT_LEN-byte
//          packets that start with SYNC_BYTE and fit at their sop. Short,
//          bad-sync and non-fitting packets are dropped whole.
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   bus (slave)  wdata/valid_in/sop_in in, rdata/valid_out/sop_out/ready_out out,
//                rempty, wfull, pkt_count, drop_pulse status
// Option: define TS_FIFO_STATS_EN to add drop_cnt[15:0] (saturating drop count)
//         and max_level[ADDR_WIDTH:0] (high-water mark of committed bytes).
module ts_packet_fifo #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    PKT_LEN    = 188,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47
) (
   input  logic               clk,
   input  logic               rst_n,
   ts_packet_fifo_if.slave    bus
`ifdef TS_FIFO_STATS_EN
   ,
   output logic [15:0]         drop_cnt,
   output logic [ADDR_WIDTH:0] max_level
`endif
);

   localparam int                  CW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] PKT_LEN_W = (ADDR_WIDTH+1)'(PKT_LEN);
   localparam logic [CW-1:0]       LAST_CNT  = CW'(PKT_LEN - 1);

   typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wstate_e;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   wstate_e               wstate_q, wstate_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic [CW-1:0]         rcnt_q, rcnt_d;
   logic [ADDR_WIDTH:0]   wr_spec_q, wr_spec_d;
   logic [ADDR_WIDTH:0]   wr_cmt_q, wr_cmt_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   pkt_count_q, pkt_count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  valid_out_q, valid_out_d;
   logic                  sop_out_q, sop_out_d;
   logic                  last_out_q, last_out_d;
   logic                  drop_pulse_q, drop_pulse_d;

   logic [ADDR_WIDTH:0]   used;
   logic [ADDR_WIDTH:0]   free_sop;
   logic                  sop_ok;
   logic                  eval_sop;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  commit;
   logic                  load;
   logic                  hs;

   assign used = wr_cmt_q - rd_ptr_q;
   // A new sop always restarts from the committed pointer, so the space it
   // may claim is everything not committed (in IDLE/DROP spec == cmt anyway).
   assign free_sop = DEPTH_W - used;
   assign sop_ok   = (bus.wdata == SYNC_BYTE) && (free_sop >= PKT_LEN_W);

   // Write FSM
   always_comb begin
      wstate_d     = wstate_q;
      wcnt_d       = wcnt_q;
      wr_spec_d    = wr_spec_q;
      wr_cmt_d     = wr_cmt_q;
      wr_en        = 1'b0;
      wr_addr      = wr_spec_q[ADDR_WIDTH-1:0];
      commit       = 1'b0;
      drop_pulse_d = 1'b0;
      eval_sop     = 1'b0;
      case (wstate_q)
         W_STORE: begin
            if (bus.valid_in && bus.sop_in) begin
               // Early sop: abandon the partial packet and re-evaluate this byte.
               drop_pulse_d = 1'b1;
               wr_spec_d    = wr_cmt_q;
               eval_sop     = 1'b1;
            end else if (bus.valid_in) begin
               wr_en     = 1'b1;
               wr_spec_d = wr_spec_q + 1'b1;
               if (wcnt_q == LAST_CNT) begin
                  commit   = 1'b1;
                  wr_cmt_d = wr_spec_q + 1'b1;
                  wcnt_d   = '0;
                  wstate_d = W_IDLE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         W_IDLE, W_DROP: begin
            eval_sop = bus.valid_in && bus.sop_in;
         end
         default: begin
            wstate_d = W_IDLE;
         end
      endcase
      if (eval_sop) begin
         if (sop_ok) begin
            wr_en     = 1'b1;
            wr_addr   = wr_cmt_q[ADDR_WIDTH-1:0];
            wr_spec_d = wr_cmt_q + 1'b1;
            wcnt_d    = CW'(1);
            wstate_d  = W_STORE;
         end else begin
            drop_pulse_d = 1'b1;
            wcnt_d       = '0;
            wstate_d     = W_DROP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= bus.wdata;
      end
   end

   // Read side: one output register refilled from committed storage whenever
   // it is empty or being handshaken this cycle.
   always_comb begin
      hs          = valid_out_q && bus.ready_out;
      load        = (used != '0) && (!valid_out_q || bus.ready_out);
      rd_ptr_d    = rd_ptr_q;
      rcnt_d      = rcnt_q;
      rdata_d     = rdata_q;
      valid_out_d = valid_out_q;
      sop_out_d   = sop_out_q;
      last_out_d  = last_out_q;
      if (load) begin
         rdata_d     = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         valid_out_d = 1'b1;
         sop_out_d   = (rcnt_q == '0);
         last_out_d  = (rcnt_q == LAST_CNT);
         rd_ptr_d    = rd_ptr_q + 1'b1;
         rcnt_d      = (rcnt_q == LAST_CNT) ? '0 : rcnt_q + 1'b1;
      end else if (hs) begin
         valid_out_d = 1'b0;
      end
   end

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (commit && !(hs && last_out_q)) begin
         pkt_count_d = pkt_count_q + 1'b1;
      end else if (!commit && hs && last_out_q) begin
         pkt_count_d = pkt_count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate_q     <= W_IDLE;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         wr_spec_q    <= '0;
         wr_cmt_q     <= '0;
         rd_ptr_q     <= '0;
         pkt_count_q  <= '0;
         rdata_q      <= '0;
         valid_out_q  <= 1'b0;
         sop_out_q    <= 1'b0;
         last_out_q   <= 1'b0;
         drop_pulse_q <= 1'b0;
      end else begin
         wstate_q     <= wstate_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         wr_spec_q    <= wr_spec_d;
         wr_cmt_q     <= wr_cmt_d;
         rd_ptr_q     <= rd_ptr_d;
         pkt_count_q  <= pkt_count_d;
         rdata_q      <= rdata_d;
         valid_out_q  <= valid_out_d;
         sop_out_q    <= sop_out_d;
         last_out_q   <= last_out_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   assign bus.rdata      = rdata_q;
   assign bus.valid_out  = valid_out_q;
   assign bus.sop_out    = sop_out_q;
   assign bus.pkt_count  = pkt_count_q;
   assign bus.drop_pulse = drop_pulse_q;
   assign bus.rempty     = (used == '0) && !valid_out_q;
   assign bus.wfull      = (free_sop < PKT_LEN_W);

`ifdef TS_FIFO_STATS_EN
   logic [15:0]         drop_cnt_q, drop_cnt_d;
   logic [ADDR_WIDTH:0] max_level_q, max_level_d;

   always_comb begin
      drop_cnt_d  = drop_cnt_q;
      max_level_d = max_level_q;
      if (drop_pulse_q && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
      if (used > max_level_q) begin
         max_level_d = used;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q  <= '0;
         max_level_q <= '0;
      end else begin
         drop_cnt_q  <= drop_cnt_d;
         max_level_q <= max_level_d;
      end
   end

   assign drop_cnt  = drop_cnt_q;
   assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_ts_packet_fifo.sv
// tb/tb_ts_packet_fifo.sv - self-checking bench for ts_packet_fifo
module tb_ts_packet_fifo;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int PL = 188;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ts_packet_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef TS_FIFO_STATS_EN
   logic [15:0] drop_cnt;
   logic [AW:0] max_level;
`endif

   ts_packet_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LEN(PL), .SYNC_BYTE(8'h47)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef TS_FIFO_STATS_EN
      , .drop_cnt(drop_cnt)
      , .max_level(max_level)
`endif
   );

   typedef struct packed {
      logic [7:0] d;
      logic       s;
   } beat_t;

   typedef struct {
      int         a_len;
      logic [7:0] a_sync;
      bit         a_commit;
      bit         has_b;
      int         exp_drops;
      int         exp_pkts;
   } vec_t;

   beat_t      got_q[$];
   beat_t      exp_q[$];
   int         checks     = 0;
   int         failures   = 0;
   int         drops_seen = 0;
   int         max_pc     = 0;
   bit         stall_pend = 0;
   logic [7:0] stall_data = '0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endfunction

   // Monitor at negedge: inputs and outputs are settled, handshake happens at the next posedge.
   always @(negedge clk) begin
      beat_t b;
      if (rst_n) begin
         if (bus.drop_pulse) drops_seen++;
         if (int'(bus.pkt_count) > max_pc) max_pc = int'(bus.pkt_count);
         if (stall_pend && bus.valid_out) chk("stall_hold", int'(bus.rdata), int'(stall_data));
         stall_pend = bus.valid_out && !bus.ready_out;
         stall_data = bus.rdata;
         if (bus.valid_out && bus.ready_out) begin
            b.d = bus.rdata;
            b.s = bus.sop_out;
            got_q.push_back(b);
         end
      end else begin
         stall_pend = 0;
      end
   end

   task automatic drive_byte(input logic [7:0] d, input logic sop);
      bus.wdata    = d;
      bus.sop_in   = sop;
      bus.valid_in = 1'b1;
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      bus.sop_in   = 1'b0;
   endtask

   // Byte 0 = first, byte i = seed + i - 1; pushed to the expected stream when it should commit.
   task automatic send_pkt(input int len, input logic [7:0] first, input logic [7:0] seed,
                           input bit commit_exp);
      logic [7:0] d;
      beat_t      b;
      for (int i = 0; i < len; i++) begin
         d = (i == 0) ? first : 8'(int'(seed) + i - 1);
         drive_byte(d, i == 0);
         if (commit_exp) begin
            b.d = d;
            b.s = (i == 0);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic drain(input string tag, input int budget);
      bit done = 0;
      bus.ready_out = 1'b1;
      for (int k = 0; k < budget && !done; k++) begin
         @(posedge clk); #1;
         done = bus.rempty && (bus.pkt_count == '0);
      end
      chk({tag, "_drain_done"}, int'(done), 1);
   endtask

   task automatic cmp_stream(input string tag);
      int bad_d = 0;
      int bad_s = 0;
      chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (got_q[i].d !== exp_q[i].d) bad_d++;
         if (got_q[i].s !== exp_q[i].s) bad_s++;
      end
      chk({tag, "_data_errs"}, bad_d, 0);
      chk({tag, "_sop_errs"}, bad_s, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   function automatic int sop_count();
      int n = 0;
      foreach (got_q[i]) if (got_q[i].s) n++;
      return n;
   endfunction

   vec_t vecs[6];

   initial begin
      int d0;
      int npk;
      bit early;

      vecs[0] = '{a_len: 188, a_sync: 8'h47, a_commit: 1, has_b: 0, exp_drops: 0, exp_pkts: 1};
      vecs[1] = '{a_len: 100, a_sync: 8'h47, a_commit: 0, has_b: 1, exp_drops: 1, exp_pkts: 1};
      vecs[2] = '{a_len: 188, a_sync: 8'h48, a_commit: 0, has_b: 1, exp_drops: 1, exp_pkts: 1};
      vecs[3] = '{a_len: 188, a_sync: 8'h47, a_commit: 1, has_b: 1, exp_drops: 0, exp_pkts: 2};
      vecs[4] = '{a_len: 1,   a_sync: 8'h47, a_commit: 0, has_b: 1, exp_drops: 1, exp_pkts: 1};
      vecs[5] = '{a_len: 188, a_sync: 8'h48, a_commit: 0, has_b: 0, exp_drops: 1, exp_pkts: 0};

      bus.wdata     = '0;
      bus.valid_in  = 1'b0;
      bus.sop_in    = 1'b0;
      bus.ready_out = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_out", int'(bus.valid_out), 0);
      chk("rst_rempty", int'(bus.rempty), 1);
      chk("rst_wfull", int'(bus.wfull), 0);
      chk("rst_pkt_count", int'(bus.pkt_count), 0);
      chk("rst_drop_pulse", int'(bus.drop_pulse), 0);
      chk("rst_rdata", int'(bus.rdata), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven packet scenarios with ready_out held high.
      for (int v = 0; v < 6; v++) begin
         d0 = drops_seen;
         max_pc = 0;
         bus.ready_out = 1'b1;
         send_pkt(vecs[v].a_len, vecs[v].a_sync, 8'h00, vecs[v].a_commit);
         if (vecs[v].has_b) send_pkt(PL, 8'h47, 8'h80, 1);
         drain($sformatf("vec%0d", v), 2000);
         chk($sformatf("vec%0d_pkts", v), sop_count(), vecs[v].exp_pkts);
         chk($sformatf("vec%0d_drops", v), drops_seen - d0, vecs[v].exp_drops);
         chk($sformatf("vec%0d_maxpc_ok", v),
             int'(max_pc >= (vecs[v].exp_pkts > 0 ? 1 : 0) && max_pc <= vecs[v].exp_pkts), 1);
         cmp_stream($sformatf("vec%0d", v));
      end

      // Latency: valid_out appears two cycles after the cycle carrying byte 187.
      bus.ready_out = 1'b1;
      send_pkt(PL, 8'h47, 8'h00, 1);
      @(negedge clk);
      chk("lat_valid_c1", int'(bus.valid_out), 0);
      chk("lat_pkt_count_c1", int'(bus.pkt_count), 1);
      @(negedge clk);
      chk("lat_valid_c2", int'(bus.valid_out), 1);
      chk("lat_sop_c2", int'(bus.sop_out), 1);
      chk("lat_rdata_c2", int'(bus.rdata), 8'h47);
      @(posedge clk); #1;
      drain("lat", 1000);
      chk("lat_pkt_count_end", int'(bus.pkt_count), 0);
      cmp_stream("lat");

      // Backpressure: two packets, ready_out toggling.
      bus.ready_out = 1'b0;
      send_pkt(PL, 8'h47, 8'h10, 1);
      send_pkt(PL, 8'h47, 8'h55, 1);
      chk("bp_pkt_count", int'(bus.pkt_count), 2);
      early = 0;
      for (int k = 0; k < 3000 && !(got_q.size() == 2 * PL && bus.rempty); k++) begin
         bus.ready_out = (k % 2 == 0);
         @(posedge clk); #1;
         if (got_q.size() < 2 * PL && bus.rempty) early = 1;
      end
      chk("bp_rempty_early", int'(early), 0);
      chk("bp_rempty_end", int'(bus.rempty), 1);
      cmp_stream("bp");

      // Full: six packets with no reads, then free one packet and send a seventh.
      bus.ready_out = 1'b0;
      d0 = drops_seen;
      for (int p = 0; p < 6; p++) begin
         send_pkt(PL, 8'h47, 8'(p * 32), p < 5);
         if (p == 3) chk("full_wfull_after4", int'(bus.wfull), 0);
         if (p == 4) chk("full_wfull_after5", int'(bus.wfull), 1);
      end
      chk("full_pkt_count", int'(bus.pkt_count), 5);
      chk("full_drops", drops_seen - d0, 1);
      bus.ready_out = 1'b1;
      for (int k = 0; k < 1000 && got_q.size() < PL; k++) begin
         @(posedge clk); #1;
      end
      bus.ready_out = 1'b0;
      chk("full_read_one", got_q.size(), PL);
      chk("full_pkt_count_after_read", int'(bus.pkt_count), 4);
      chk("full_wfull_after_read", int'(bus.wfull), 0);
      send_pkt(PL, 8'h47, 8'hC3, 1);
      chk("full_pkt_count_7th", int'(bus.pkt_count), 5);
      chk("full_drops_7th", drops_seen - d0, 1);
      drain("full", 3000);
      cmp_stream("full");

`ifdef TS_FIFO_STATS_EN
      chk("stats_drop_cnt", int'(drop_cnt), 5);
`endif

      // Reset mid-packet with a committed packet waiting at the output.
      bus.ready_out = 1'b0;
      d0 = drops_seen;
      send_pkt(PL, 8'h47, 8'h00, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rstm_valid_pre", int'(bus.valid_out), 1);
      send_pkt(90, 8'h47, 8'h20, 0);
      bus.wdata    = 8'h20 + 8'd89;
      bus.valid_in = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_valid_out", int'(bus.valid_out), 0);
      chk("rstm_sop_out", int'(bus.sop_out), 0);
      chk("rstm_rdata", int'(bus.rdata), 0);
      chk("rstm_rempty", int'(bus.rempty), 1);
      chk("rstm_wfull", int'(bus.wfull), 0);
      chk("rstm_pkt_count", int'(bus.pkt_count), 0);
      chk("rstm_drop_pulse", int'(bus.drop_pulse), 0);
`ifdef TS_FIFO_STATS_EN
      chk("rstm_drop_cnt", int'(drop_cnt), 0);
`endif
      bus.valid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      got_q.delete();
      exp_q.delete();
      bus.ready_out = 1'b1;
      send_pkt(PL, 8'h47, 8'h3A, 1);
      drain("rstm", 1000);
      chk("rstm_drops", drops_seen - d0, 0);
      cmp_stream("rstm");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
